// File: rtl/de0_hex_display_ctrl.sv
// de0_hex_display_ctrl: active-low 7-seg+DP driver for DIGITS hex digits.
// Optional PWM dimming when HEX_DIM_EN is defined (adds bright port).
module de0_hex_display_ctrl #(
   parameter int DIGITS   = 4,
   parameter int CLK_HZ   = 50000000,
   parameter int BLINK_HZ = 2
) (
   input  logic                clk_50,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] value,
   input  logic                value_valid,
   input  logic [DIGITS-1:0]   dp,
   input  logic                lz_blank,
   input  logic [DIGITS-1:0]   blink_en,
`ifdef HEX_DIM_EN
   input  logic [3:0]          bright,
`endif
   output logic [8*DIGITS-1:0] hex_out,
   output logic                changed
);

   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

   if (BLINK_DIV < 1) begin : g_bad_div
      $error("BLINK_DIV must be >= 1");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("DIGITS must be 1..8");
   end

   logic [4*DIGITS-1:0] held;
   logic [CW-1:0]       blink_cnt;
   logic                blink_on;
   logic                lead;
   logic [DIGITS-1:0]   lz_mask;
   logic [8*DIGITS-1:0] hex_nxt;
   logic                load;
`ifdef HEX_DIM_EN
   logic [3:0]          pwm_cnt;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0011000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign load = value_valid && (value != held);

   // Blank zeros from the top digit down; digit 0 always shows.
   always_comb begin
      lead    = 1'b1;
      lz_mask = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lead       = lead & (held[4*i +: 4] == 4'h0);
         lz_mask[i] = lead & lz_blank;
      end
   end

   always_comb begin
      hex_nxt = '1;
      for (int i = 0; i < DIGITS; i++) begin
         hex_nxt[8*i +: 8] = {~dp[i],
            lz_mask[i] ? 7'h7F : seg7(held[4*i +: 4])};
         if (blink_en[i] && !blink_on)
            hex_nxt[8*i +: 8] = 8'hFF;
      end
`ifdef HEX_DIM_EN
      if (!(bright == 4'hF || pwm_cnt < bright))
         hex_nxt = '1;
`endif
   end

   always_ff @(posedge clk_50) begin
      if (rst) begin
         held      <= '0;
         changed   <= 1'b0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         hex_out   <= '1;
      end else begin
         changed <= load;
         if (load)
            held <= value;
         if (blink_cnt == LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + CW'(1);
         end
         hex_out <= hex_nxt;
      end
   end

`ifdef HEX_DIM_EN
   always_ff @(posedge clk_50) begin
      if (rst)
         pwm_cnt <= 4'd0;
      else
         pwm_cnt <= pwm_cnt + 4'd1;
   end
`endif

endmodule
